board_controller: RTL and testbench

Holds the 3x3 tic-tac-toe game state (cell contents, cursor, turn, win/draw result) and maps the current VGA pixel coordinate to the per-pixel cell attributes that drive the downstream `renderer` stage. It sits between the debounced push-button inputs and `renderer`. It supplies `render`, `mode`, `highlight`, `lx` and `ly` for each pixel, and `renderer` combines them with `blanking` to produce `rgb`.

---
 rtl/board_controller.sv | 184 ++++++++++++++++++
 tb/tb_board_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/board_controller.sv
// Tic-tac-toe game state for a 3x3 board plus per-pixel cell decode for the renderer.
// Pixel outputs are purely combinational; game state advances on button rising edges.
module board_controller #(
   parameter int unsigned X0   = 150,
   parameter int unsigned Y0   = 70,
   parameter int unsigned CELL = 100,
   parameter int unsigned GAP  = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_sel,
   output logic       render,
   output logic [9:0] lx,
   output logic [9:0] ly,
   output logic [1:0] mode,
   output logic       highlight,
   output logic [1:0] status,
   output logic       turn
);

   localparam int unsigned Pitch = CELL + GAP;
   localparam int unsigned BaseX = X0 + GAP;
   localparam int unsigned BaseY = Y0 + GAP;

   // Bit i of each mask is cell i (row-major).
   localparam logic [8:0] Lines [8] = '{
      9'b000_000_111, 9'b000_111_000, 9'b111_000_000,
      9'b001_001_001, 9'b010_010_010, 9'b100_100_100,
      9'b100_010_001, 9'b001_010_100
   };

   typedef enum logic [1:0] {StPlay, StCheck, StWin, StDraw} state_e;

   state_e      state_q, state_d;
   logic [8:0]  xs_q, xs_d;
   logic [8:0]  os_q, os_d;
   logic [8:0]  win_mask_q, win_mask_d;
   logic [3:0]  cursor_q, cursor_d;
   logic        turn_q, turn_d;
   logic [1:0]  status_q, status_d;
   logic [4:0]  prev_q, prev_d;

   logic [4:0]  btn_vec, rise;
   logic [8:0]  occupied, mover, line_hit;

   logic        in_x, in_y;
   logic [1:0]  col, row;
   logic [9:0]  off_x, off_y;
   logic [3:0]  idx;

   // Pixel decode
   always_comb begin
      in_x  = 1'b0;
      in_y  = 1'b0;
      col   = 2'd0;
      row   = 2'd0;
      off_x = 10'd0;
      off_y = 10'd0;
      for (int unsigned c = 0; c < 3; c++) begin
         if (32'(x) >= BaseX + c * Pitch && 32'(x) < BaseX + c * Pitch + CELL) begin
            in_x  = 1'b1;
            col   = 2'(c);
            off_x = 10'(32'(x) - (BaseX + c * Pitch));
         end
         if (32'(y) >= BaseY + c * Pitch && 32'(y) < BaseY + c * Pitch + CELL) begin
            in_y  = 1'b1;
            row   = 2'(c);
            off_y = 10'(32'(y) - (BaseY + c * Pitch));
         end
      end
      idx       = {2'b00, row} * 4'd3 + {2'b00, col};
      render    = in_x && in_y;
      lx        = 10'd0;
      ly        = 10'd0;
      mode      = 2'b00;
      highlight = 1'b0;
      if (render) begin
         lx        = off_x;
         ly        = off_y;
         mode      = {os_q[idx], xs_q[idx]};
         if (state_q == StWin && win_mask_q[idx]) mode = 2'b11;
         highlight = (idx == cursor_q) && (state_q == StPlay);
      end
   end

   assign status  = status_q;
   assign turn    = turn_q;
   assign btn_vec = {btn_sel, btn_up, btn_down, btn_left, btn_right};

   // Game FSM and next-state logic
   always_comb begin
      state_d    = state_q;
      xs_d       = xs_q;
      os_d       = os_q;
      win_mask_d = win_mask_q;
      cursor_d   = cursor_q;
      turn_d     = turn_q;
      status_d   = status_q;
      prev_d     = btn_vec;
      rise       = btn_vec & ~prev_q;
      occupied   = xs_q | os_q;
      mover      = turn_q ? os_q : xs_q;
      line_hit   = 9'd0;
      for (int l = 0; l < 8; l++) begin
         if ((mover & Lines[l]) == Lines[l]) line_hit = line_hit | Lines[l];
      end

      case (state_q)
         StPlay: begin
            if (rise[4]) begin
               if (!occupied[cursor_q]) begin
                  if (turn_q) os_d[cursor_q] = 1'b1;
                  else        xs_d[cursor_q] = 1'b1;
                  state_d = StCheck;
               end
            end else if (rise[3]) begin
               if (cursor_q >= 4'd3) cursor_d = cursor_q - 4'd3;
            end else if (rise[2]) begin
               if (cursor_q <= 4'd5) cursor_d = cursor_q + 4'd3;
            end else if (rise[1]) begin
               if (cursor_q != 4'd0 && cursor_q != 4'd3 && cursor_q != 4'd6)
                  cursor_d = cursor_q - 4'd1;
            end else if (rise[0]) begin
               if (cursor_q != 4'd2 && cursor_q != 4'd5 && cursor_q != 4'd8)
                  cursor_d = cursor_q + 4'd1;
            end
         end
         StCheck: begin
            if (line_hit != 9'd0) begin
               win_mask_d = line_hit;
               status_d   = turn_q ? 2'b10 : 2'b01;
               state_d    = StWin;
            end else if (&occupied) begin
               status_d = 2'b11;
               state_d  = StDraw;
            end else begin
               turn_d  = ~turn_q;
               state_d = StPlay;
            end
         end
         StWin, StDraw: begin
            if (rise[4]) begin
               xs_d       = 9'd0;
               os_d       = 9'd0;
               win_mask_d = 9'd0;
               cursor_d   = 4'd4;
               turn_d     = 1'b0;
               status_d   = 2'b00;
               state_d    = StPlay;
            end
         end
         default: state_d = StPlay;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StPlay;
         xs_q       <= 9'd0;
         os_q       <= 9'd0;
         win_mask_q <= 9'd0;
         cursor_q   <= 4'd4;
         turn_q     <= 1'b0;
         status_q   <= 2'b00;
         prev_q     <= 5'd0;
      end else begin
         state_q    <= state_d;
         xs_q       <= xs_d;
         os_q       <= os_d;
         win_mask_q <= win_mask_d;
         cursor_q   <= cursor_d;
         turn_q     <= turn_d;
         status_q   <= status_d;
         prev_q     <= prev_d;
      end
   end

endmodule

// File: tb/tb_board_controller.sv
// Directed self-checking bench for board_controller: geometry, cursor, placement,
// win/draw detection, restart and asynchronous reset.
module tb_board_controller;

   localparam logic [4:0] SEL   = 5'b10000;
   localparam logic [4:0] UP    = 5'b01000;
   localparam logic [4:0] DOWN  = 5'b00100;
   localparam logic [4:0] LEFT  = 5'b00010;
   localparam logic [4:0] RIGHT = 5'b00001;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] x, y;
   logic [4:0] btn;
   logic       render, highlight, turn;
   logic [9:0] lx, ly;
   logic [1:0] mode, status;

   int n_cmp  = 0;
   int n_fail = 0;
   int cur    = 4;

   board_controller dut (
      .clk       (clk),
      .rst       (rst),
      .x         (x),
      .y         (y),
      .btn_up    (btn[3]),
      .btn_down  (btn[2]),
      .btn_left  (btn[1]),
      .btn_right (btn[0]),
      .btn_sel   (btn[4]),
      .render    (render),
      .lx        (lx),
      .ly        (ly),
      .mode      (mode),
      .highlight (highlight),
      .status    (status),
      .turn      (turn)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pix(input int px, input int py);
      x = 10'(px);
      y = 10'(py);
      #1;
   endtask

   task automatic press(input logic [4:0] b);
      @(negedge clk);
      btn = b;
      @(negedge clk);
      btn = 5'b0;
   endtask

   task automatic move_to(input int t);
      while (cur / 3 > t / 3) begin press(UP);    cur -= 3; end
      while (cur / 3 < t / 3) begin press(DOWN);  cur += 3; end
      while (cur % 3 > t % 3) begin press(LEFT);  cur -= 1; end
      while (cur % 3 < t % 3) begin press(RIGHT); cur += 1; end
   endtask

   task automatic place(input int t);
      move_to(t);
      press(SEL);
      @(negedge clk);
   endtask

   // '.' empty, 'X', 'O', 'W' winning-line cell; character i is cell i.
   function automatic logic [17:0] pat(input string s);
      logic [17:0] r = '0;
      for (int i = 0; i < 9; i++) begin
         case (s[i])
            "X":     r[2*i +: 2] = 2'b01;
            "O":     r[2*i +: 2] = 2'b10;
            "W":     r[2*i +: 2] = 2'b11;
            default: r[2*i +: 2] = 2'b00;
         endcase
      end
      return r;
   endfunction

   task automatic check_board(input string tag, input string s, input logic [8:0] hl_exp);
      logic [17:0] modes;
      logic [8:0]  hl;
      for (int i = 0; i < 9; i++) begin
         pix(165 + 110 * (i % 3), 87 + 110 * (i / 3));
         modes[2*i +: 2] = mode;
         hl[i]           = highlight;
      end
      check({tag, " modes"}, 32'(modes), 32'(pat(s)));
      check({tag, " highlight"}, 32'(hl), 32'(hl_exp));
   endtask

   initial begin
      rst = 1'b1;
      btn = 5'b0;
      x   = 10'd0;
      y   = 10'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset state and geometry
      pix(315, 235);
      check("ctr render", 32'(render), 1);
      check("ctr lx", 32'(lx), 45);
      check("ctr ly", 32'(ly), 45);
      check("ctr mode", 32'(mode), 0);
      check("ctr highlight", 32'(highlight), 1);
      check("rst status", 32'(status), 0);
      check("rst turn", 32'(turn), 0);
      pix(265, 235);
      check("border render", 32'(render), 0);
      check("border mode", 32'(mode), 0);
      check("border lx", 32'(lx), 0);
      check("border ly", 32'(ly), 0);
      pix(259, 179);
      check("c0 corner render", 32'(render), 1);
      check("c0 corner lx", 32'(lx), 99);
      check("c0 corner ly", 32'(ly), 99);
      pix(160, 80);
      check("c0 origin lx", 32'(lx), 0);
      pix(159, 80);
      check("left of board", 32'(render), 0);
      pix(480, 80);
      check("right of board", 32'(render), 0);
      pix(380, 399);
      check("c8 bottom", 32'(render), 1);
      check("c8 bottom ly", 32'(ly), 99);

      // Cursor saturation and hold
      press(UP); press(UP); press(LEFT); press(LEFT);
      cur = 0;
      check_board("cursor0", ".........", 9'b000000001);
      @(negedge clk);
      btn = RIGHT;
      repeat (20) @(negedge clk);
      btn = 5'b0;
      cur = 1;
      check_board("hold right", ".........", 9'b000000010);
      press(LEFT);
      cur = 0;
      press(SEL);
      pix(160, 80);
      check("sel c0 mode", 32'(mode), 1);
      check("turn during check", 32'(turn), 0);
      @(negedge clk);
      check("turn after check", 32'(turn), 1);

      // Row win for X
      place(3); place(1); place(4);
      move_to(2);
      press(SEL);
      check("status in check", 32'(status), 0);
      @(negedge clk);
      check("row win status", 32'(status), 1);
      check("row win turn", 32'(turn), 0);
      check_board("row win", "WWWOO....", 9'b0);
      press(LEFT); press(DOWN);
      check("win ignores dirs", 32'(status), 1);
      check_board("win after dirs", "WWWOO....", 9'b0);

      // Restart, occupied cell, simultaneous sel+right
      press(SEL);
      cur = 4;
      check("restart status", 32'(status), 0);
      check("restart turn", 32'(turn), 0);
      check_board("restart", ".........", 9'b000010000);
      place(4);
      check("after X4 turn", 32'(turn), 1);
      press(SEL);
      @(negedge clk);
      check("occupied turn", 32'(turn), 1);
      check_board("occupied", "....X....", 9'b000010000);
      move_to(3);
      press(SEL | RIGHT);
      @(negedge clk);
      check("sel+right turn", 32'(turn), 0);
      check_board("sel+right", "...OX....", 9'b000001000);

      // Draw then restart
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      cur = 4;
      check_board("rst clears", ".........", 9'b000010000);
      place(0); place(1); place(2); place(4); place(3);
      place(5); place(7); place(6); place(8);
      check("draw status", 32'(status), 3);
      check("draw turn", 32'(turn), 0);
      check_board("draw", "XOXXOOOXX", 9'b0);
      press(SEL);
      cur = 4;
      check("draw restart status", 32'(status), 0);
      check("draw restart turn", 32'(turn), 0);
      check_board("draw restart", ".........", 9'b000010000);

      // Win on the 9th move beats draw
      place(0); place(2); place(1); place(3); place(4);
      place(6); place(5); place(8); place(7);
      check("ninth win status", 32'(status), 1);
      check_board("ninth win", "XWOOWXOWO", 9'b0);

      // Asynchronous reset in WIN
      @(negedge clk);
      pix(275, 87);
      check("pre-rst win mode", 32'(mode), 3);
      #2 rst = 1'b1;
      #1;
      check("async rst win status", 32'(status), 0);
      check("async rst win mode", 32'(mode), 0);
      @(negedge clk);
      rst = 1'b0;
      cur = 4;

      // Asynchronous reset in CHECK
      press(SEL);
      pix(275, 197);
      check("pre-rst check mode", 32'(mode), 1);
      #1 rst = 1'b1;
      #1;
      check("async rst check mode", 32'(mode), 0);
      check("async rst check turn", 32'(turn), 0);
      check("async rst check hl", 32'(highlight), 1);
      @(posedge clk);
      #1;
      check("held rst turn", 32'(turn), 0);
      @(negedge clk);
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
